// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, exception/ERET redirect and flush,
// and a multi-cycle divide sequencer that holds EX while the divider runs.
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_wait,
    input  logic        id_load_use,
    input  logic        ex_div_start,
    input  logic        mem_wait,
    input  logic        mem_exc_valid,
    input  logic [31:0] mem_exc_target,
    output logic [4:0]  stall,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic        div_busy,
    output logic        div_done
);

    localparam logic [6:0] DIV_LOAD = 7'(DIV_CYCLES - 1);

    typedef enum logic {
        EXC_RUN           = 1'b0,
        EXC_REDIRECT_WAIT = 1'b1
    } exc_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    exc_state_t  exc_state_r;
    exc_state_t  exc_state_next_s;
    logic [31:0] target_r;
    logic [31:0] target_next_s;
    logic [31:0] new_pc_r;
    logic [31:0] redirect_pc_s;
    logic        exc_accept_s;
    logic        flush_s;
    logic        redirect_s;

    div_state_t  div_state_r;
    div_state_t  div_state_step_s;
    div_state_t  div_state_next_s;
    logic [6:0]  div_cnt_r;
    logic [6:0]  div_cnt_step_s;
    logic [6:0]  div_cnt_next_s;
    logic        div_start_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic        div_stall_s;
    logic [4:0]  stall_s;

    assign exc_accept_s = mem_exc_valid && !mem_wait && (exc_state_r == EXC_RUN);

    // Exception FSM: redirect immediately when IF is free, otherwise park the target and keep flushing.
    always_comb begin
        exc_state_next_s = exc_state_r;
        target_next_s    = target_r;
        flush_s          = 1'b0;
        redirect_s       = 1'b0;
        redirect_pc_s    = new_pc_r;
        case (exc_state_r)
            EXC_RUN: begin
                if (exc_accept_s) begin
                    flush_s = 1'b1;
                    if (if_wait) begin
                        exc_state_next_s = EXC_REDIRECT_WAIT;
                        target_next_s    = mem_exc_target;
                    end else begin
                        redirect_s    = 1'b1;
                        redirect_pc_s = mem_exc_target;
                    end
                end else begin
                    exc_state_next_s = EXC_RUN;
                end
            end
            EXC_REDIRECT_WAIT: begin
                flush_s = 1'b1;
                if (!if_wait) begin
                    redirect_s       = 1'b1;
                    redirect_pc_s    = target_r;
                    exc_state_next_s = EXC_RUN;
                end else begin
                    exc_state_next_s = EXC_REDIRECT_WAIT;
                end
            end
            default: begin
                exc_state_next_s = EXC_RUN;
            end
        endcase
    end

    // Divide sequencer: the start cycle counts as the first stall cycle, so BUSY lasts DIV_CYCLES-1 cycles.
    always_comb begin
        div_state_step_s = div_state_r;
        div_cnt_step_s   = div_cnt_r;
        div_start_s      = 1'b0;
        div_busy_s       = 1'b0;
        div_done_s       = 1'b0;
        case (div_state_r)
            DIV_IDLE: begin
                if (ex_div_start && !mem_wait && !flush_s) begin
                    div_start_s      = 1'b1;
                    div_state_step_s = DIV_BUSY;
                    div_cnt_step_s   = DIV_LOAD;
                end else begin
                    div_state_step_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                div_busy_s = 1'b1;
                if (mem_wait) begin
                    div_cnt_step_s = div_cnt_r;
                end else if (div_cnt_r <= 7'd1) begin
                    div_cnt_step_s   = 7'd0;
                    div_state_step_s = DIV_DONE;
                end else begin
                    div_cnt_step_s = div_cnt_r - 7'd1;
                end
            end
            DIV_DONE: begin
                div_done_s       = !flush_s;
                div_state_step_s = DIV_IDLE;
            end
            default: begin
                div_state_step_s = DIV_IDLE;
                div_cnt_step_s   = 7'd0;
            end
        endcase
    end

    assign div_state_next_s = flush_s ? DIV_IDLE : div_state_step_s;
    assign div_cnt_next_s   = flush_s ? 7'd0 : div_cnt_step_s;
    assign div_stall_s      = div_start_s || div_busy_s;

    // Stall vector: OR of prefix masks, so any set bit implies all younger-stage bits are set.
    always_comb begin
        stall_s = 5'b00000;
        if (rst || exc_accept_s) begin
            stall_s = 5'b00000;
        end else begin
            if (if_wait) begin
                stall_s = stall_s | 5'b00001;
            end else begin
                stall_s = stall_s;
            end
            if (id_load_use) begin
                stall_s = stall_s | 5'b00011;
            end else begin
                stall_s = stall_s;
            end
            if (div_stall_s) begin
                stall_s = stall_s | 5'b00111;
            end else begin
                stall_s = stall_s;
            end
            if (mem_wait) begin
                stall_s = stall_s | 5'b01111;
            end else begin
                stall_s = stall_s;
            end
            if (exc_state_r == EXC_REDIRECT_WAIT) begin
                stall_s = stall_s | 5'b00001;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    // Outputs forced to reset values whenever rst is high.
    always_comb begin
        stall = stall_s;
        if (rst) begin
            flush        = 1'b0;
            new_pc_valid = 1'b0;
            new_pc       = 32'h0000_0000;
            div_busy     = 1'b0;
            div_done     = 1'b0;
        end else begin
            flush        = flush_s;
            new_pc_valid = redirect_s;
            new_pc       = redirect_pc_s;
            div_busy     = div_busy_s;
            div_done     = div_done_s;
        end
    end

    // State registers; new_pc_r remembers the last redirect address.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_state_r <= EXC_RUN;
            target_r    <= 32'h0000_0000;
            new_pc_r    <= 32'h0000_0000;
            div_state_r <= DIV_IDLE;
            div_cnt_r   <= 7'd0;
        end else begin
            exc_state_r <= exc_state_next_s;
            target_r    <= target_next_s;
            new_pc_r    <= redirect_pc_s;
            div_state_r <= div_state_next_s;
            div_cnt_r   <= div_cnt_next_s;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with DIV_CYCLES=4; expected values computed by hand.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        if_wait;
    logic        id_load_use;
    logic        ex_div_start;
    logic        mem_wait;
    logic        mem_exc_valid;
    logic [31:0] mem_exc_target;
    logic [4:0]  stall;
    logic        flush;
    logic        new_pc_valid;
    logic [31:0] new_pc;
    logic        div_busy;
    logic        div_done;

    int vectors = 0;
    int fails   = 0;

    pipeline_ctrl #(.DIV_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_wait        (if_wait),
        .id_load_use    (id_load_use),
        .ex_div_start   (ex_div_start),
        .mem_wait       (mem_wait),
        .mem_exc_valid  (mem_exc_valid),
        .mem_exc_target (mem_exc_target),
        .stall          (stall),
        .flush          (flush),
        .new_pc_valid   (new_pc_valid),
        .new_pc         (new_pc),
        .div_busy       (div_busy),
        .div_done       (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] e_stall, input logic e_flush,
                              input logic e_npv, input logic [31:0] e_pc,
                              input logic e_busy, input logic e_done);
        #1;
        chk({tag, ".stall"},    {27'd0, stall},        {27'd0, e_stall});
        chk({tag, ".flush"},    {31'd0, flush},        {31'd0, e_flush});
        chk({tag, ".npv"},      {31'd0, new_pc_valid}, {31'd0, e_npv});
        chk({tag, ".new_pc"},   new_pc,                e_pc);
        chk({tag, ".div_busy"}, {31'd0, div_busy},     {31'd0, e_busy});
        chk({tag, ".div_done"}, {31'd0, div_done},     {31'd0, e_done});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic iw, input logic lu, input logic ds,
                         input logic mw, input logic ev, input logic [31:0] et);
        rst            = r;
        if_wait        = iw;
        id_load_use    = lu;
        ex_div_start   = ds;
        mem_wait       = mw;
        mem_exc_valid  = ev;
        mem_exc_target = et;
    endtask

    initial begin
        // reset with busy inputs: everything must read as reset values
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE0000);
        expect_out("rst0", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_out("rst1", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("idle", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // load-use single cycle
        step(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("lu_on", 5'b00011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("lu_off", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // plain divide: 4 stall cycles, 3 busy, done on 5th
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("div_start", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("div_busy", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        step();
        expect_out("div_done", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("div_after", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // divide with two mem_wait cycles and combined stall sources
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("dw_start", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("dw_lu_div", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(); drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("dw_all4", 5'b01111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("dw_mw2", 5'b01111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("dw_b3", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_out("dw_b4", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_out("dw_done", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("dw_after", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // immediate exception redirect, stall sources suppressed
        step(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC00380);
        expect_out("exc_now", 5'b00000, 1'b1, 1'b1, 32'hBFC00380, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("exc_hold", 5'b00000, 1'b0, 1'b0, 32'hBFC00380, 1'b0, 1'b0);

        // deferred redirect while IF busy for 3 cycles
        step(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
        expect_out("rw_accept", 5'b00000, 1'b1, 1'b0, 32'hBFC00380, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        expect_out("rw_wait1", 5'b00001, 1'b1, 1'b0, 32'hBFC00380, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rw_wait2", 5'b00001, 1'b1, 1'b0, 32'hBFC00380, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rw_fire", 5'b00001, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
        step();
        expect_out("rw_after", 5'b00000, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);

        // exception blocked by mem_wait
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0BAD0000);
        expect_out("exc_mw", 5'b01111, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("exc_mw_after", 5'b00000, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);

        // flush abandons a running divide
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("fd_start", 5'b00111, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
        step();
        expect_out("fd_busy", 5'b00111, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80000180);
        expect_out("fd_flush", 5'b00000, 1'b1, 1'b1, 32'h80000180, 1'b1, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("fd_idle", 5'b00000, 1'b0, 1'b0, 32'h80000180, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("fd_nodone", 5'b00000, 1'b0, 1'b0, 32'h80000180, 1'b0, 1'b0);
        end

        // reset mid-divide
        step(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("rd_start", 5'b00111, 1'b0, 1'b0, 32'h80000180, 1'b0, 1'b0);
        step();
        expect_out("rd_busy", 5'b00111, 1'b0, 1'b0, 32'h80000180, 1'b1, 1'b0);
        step(); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("rd_rst", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rd_idle", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("rd_nodone", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // reset while waiting to redirect
        step(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA);
        expect_out("rr_accept", 5'b00000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rr_rst", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rr_nopc", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_out("rr_nopc2", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, number of cycles a divide occupies EX (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_wait  input  1  instruction fetch outstanding; IF cannot accept a new PC.
REQ-005 SHALL have port id_load_use  input  1  ID instruction reads the destination of the load currently in EX.
REQ-006 SHALL have port ex_div_start  input  1  EX holds a divide instruction that needs to start.
REQ-007 SHALL have port mem_wait  input  1  data memory access in MEM not yet complete.
REQ-008 SHALL have port mem_exc_valid  input  1  MEM instruction raises an exception or ERET.
REQ-009 SHALL have port mem_exc_target  input  32  redirect PC for mem_exc_valid.
REQ-010 SHALL have port stall  output  5  per-stage stall, bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB; drives stall_current_stage/stall_next_stage of the stage registers.
REQ-011 SHALL have port flush  output  1  clears all pipeline stage registers.
REQ-012 SHALL have port new_pc_valid  output  1  one-cycle redirect strobe to IF.
REQ-013 SHALL have port new_pc  output  32  redirect address, valid with new_pc_valid.
REQ-014 SHALL have port div_busy  output  1  divider occupying EX.
REQ-015 SHALL have port div_done  output  1  one-cycle strobe, divide result ready in EX.

Function
REQ-016 stall SHALL be combinational, the OR of masks: if_wait 5'b00001; id_load_use 5'b00011; div stall 5'b00111; mem_wait 5'b01111; REDIRECT_WAIT 5'b00001; bit4 always 0.
REQ-017 stall SHALL be prefix-closed: any asserted bit implies all lower bits asserted.
REQ-018 Exception accept SHALL be mem_exc_valid & !mem_wait & exc FSM in RUN; ignored otherwise.
REQ-019 On accept, flush SHALL be 1 combinationally in that cycle and stall SHALL be 5'b00000 in that cycle.
REQ-020 Exc FSM states RUN, REDIRECT_WAIT; on accept with if_wait=0: stay RUN, new_pc_valid=1 and new_pc=mem_exc_target in the same cycle.
REQ-021 On accept with if_wait=1: latch mem_exc_target into a target register, go to REDIRECT_WAIT; no new_pc_valid this cycle.
REQ-022 In REDIRECT_WAIT: flush=1 every cycle; when if_wait=0, new_pc_valid=1 for one cycle with new_pc=latched target, next state RUN.
REQ-023 new_pc SHALL hold its last driven value when new_pc_valid=0.
REQ-024 Div FSM states IDLE, BUSY, DONE; IDLE->BUSY when ex_div_start & !mem_wait & !flush, counter loaded DIV_CYCLES-1.
REQ-025 BUSY: counter decrements each cycle mem_wait=0, holds when mem_wait=1; at counter 0 with mem_wait=0 -> DONE.
REQ-026 DONE: div_done=1 one cycle, div stall released, next state IDLE; ex_div_start in DONE SHALL NOT restart.
REQ-027 Div stall SHALL be asserted in IDLE when ex_div_start starts and in all of BUSY; div_busy=1 in BUSY only.
REQ-028 Divide of DIV_CYCLES total stall cycles: start cycle plus DIV_CYCLES-1 BUSY cycles, DONE cycle unstalled, with mem_wait=0 throughout.
REQ-029 flush SHALL force div FSM to IDLE next cycle, counter cleared, no div_done.
REQ-030 Simultaneous id_load_use and div stall SHALL give 5'b00111; all four sources give 5'b01111.

Reset
REQ-031 With rst=1 at posedge: stall=0, flush=0, new_pc_valid=0, new_pc=32'h0, div_busy=0, div_done=0, exc FSM RUN, div FSM IDLE, counter 0.
REQ-032 Reset mid-divide or in REDIRECT_WAIT SHALL abandon the operation with no div_done and no new_pc_valid afterwards.
REQ-033 Outputs SHALL be reset values in any cycle where rst=1, regardless of inputs.

Verification
REQ-034 id_load_use=1 one cycle, others 0 -> stall=5'b00011 that cycle only.
REQ-035 DIV_CYCLES=4, ex_div_start held -> stall=5'b00111 for 4 cycles, div_busy 3 cycles, div_done=1 on 5th cycle with stall=0.
REQ-036 Divide in BUSY, mem_wait=1 for 2 cycles -> stall=5'b01111, counter frozen, div_done delayed exactly 2 cycles.
REQ-037 mem_exc_valid=1, target 32'hBFC00380, if_wait=0 -> same cycle flush=1, new_pc_valid=1, new_pc=32'hBFC00380, stall=0.
REQ-038 mem_exc_valid with if_wait=1 for 3 cycles -> flush=1 for 4 cycles, new_pc_valid pulses once in the cycle if_wait drops, new_pc=latched target.
REQ-039 rst=1 during BUSY with counter 10 -> next cycle all outputs 0, div_done never asserts.
